fixed_softmax_ctrl: RTL
=======================

FIXED_SOFTMAX_CTRL -- requirements
Module: fixed_softmax_ctrl

Interface
REQ-001 Parameter IN_DEPTH, default 10: number of input blocks per softmax vector; legal range 2..1024.
REQ-002 Parameter ADDR_WIDTH, default $clog2(IN_DEPTH): width of the block-buffer address.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 data_in_0_valid  in  1  upstream block valid.
REQ-007 data_in_0_ready  out  1  controller accepts an input block.
REQ-008 buf_wr_en  out  1  write the current exp block into the buffer.
REQ-009 buf_wr_addr  out  ADDR_WIDTH  buffer write slot.
REQ-010 acc_en  out  1  accumulator captures the current block sum.
REQ-011 acc_first  out  1  accumulator loads rather than adds (block 0).
REQ-012 sum_zero  in  1  accumulated vector sum equals zero; sampled in SUM.
REQ-013 sum_load  out  1  divisor register captures the accumulator output.
REQ-014 div_start  out  1  one-cycle pulse that launches the divider on one buffered block.
REQ-015 div_done  in  1  one-cycle pulse: divider result ready.
REQ-016 buf_rd_addr  out  ADDR_WIDTH  buffer read slot feeding the divider.
REQ-017 data_out_0_valid  out  1  normalised block available downstream.
REQ-018 data_out_0_ready  in  1  downstream accepts the block.
REQ-019 out_last  out  1  current output is the final block of the vector.
REQ-020 out_sat  out  1  current vector had a zero sum; the datapath emits saturated output.

Function
REQ-021 FSM states: FILL, SUM, DIV_ISSUE, DIV_WAIT, OUT.
REQ-022 FILL: data_in_0_ready=1; each handshake (valid&ready) sets buf_wr_en=1, acc_en=1, buf_wr_addr=wr_cnt and acc_first=(wr_cnt==0), all combinationally in the same cycle; wr_cnt then increments.
REQ-023 A FILL handshake with wr_cnt==IN_DEPTH-1 SHALL clear wr_cnt and move to SUM.
REQ-024 SUM lasts exactly one cycle: sum_load=1, sum_zero latched into sat_q, rd_cnt cleared; next state is OUT if sum_zero=1, else DIV_ISSUE.
REQ-025 DIV_ISSUE lasts one cycle: div_start=1; next state is DIV_WAIT; div_done is ignored in this state.
REQ-026 DIV_WAIT: hold until div_done=1, then go to OUT; there is no timeout.
REQ-027 OUT: data_out_0_valid=1, out_last=(rd_cnt==IN_DEPTH-1), out_sat=sat_q; hold until data_out_0_ready=1.
REQ-028 OUT handshake, non-last: rd_cnt+1; next state is DIV_ISSUE, or OUT again if sat_q=1.
REQ-029 OUT handshake, last: rd_cnt=0, sat_q=0; next state is FILL.
REQ-030 buf_rd_addr=rd_cnt, held stable from DIV_ISSUE through the OUT handshake.
REQ-031 data_in_0_ready=0 in every state except FILL; no new vector overlaps the output of the current vector.
REQ-032 div_done arriving outside DIV_WAIT SHALL be ignored and SHALL NOT change state.
REQ-033 data_out_0_valid, once asserted, SHALL remain high with out_last/out_sat/buf_rd_addr stable until the handshake.
REQ-034 buf_wr_en, acc_en, sum_load and div_start SHALL never be asserted in the same cycle as each other, except buf_wr_en with acc_en.
REQ-035 Counters wr_cnt and rd_cnt SHALL never exceed IN_DEPTH-1.

Reset
REQ-036 rst=1 SHALL force state=FILL, wr_cnt=0, rd_cnt=0, sat_q=0 at the next edge, from any state including mid-vector.
REQ-037 While rst=1, every output SHALL be 0, including data_in_0_ready.
REQ-038 After reset, the first accepted block is treated as block 0 (acc_first=1); partial-vector buffer contents are discarded.

Verification
REQ-039 IN_DEPTH=4, 4 back-to-back input blocks -> buf_wr_addr 0,1,2,3, acc_first only on the first, one SUM cycle with sum_load=1, then 4 div_start pulses and 4 outputs with out_last only on rd 3.
REQ-040 sum_zero=1 in SUM -> no div_start for the whole vector; 4 outputs with out_sat=1; the next vector has out_sat=0.
REQ-041 div_done delayed 7 cycles, plus a spurious div_done in FILL and DIV_ISSUE -> no state change from the spurious pulses; data_out_0_valid rises the cycle after the real div_done.
REQ-042 data_out_0_ready held low 5 cycles -> valid, out_last, buf_rd_addr stable and data_in_0_ready=0 throughout.
REQ-043 rst asserted after 2 of 4 blocks, and again in DIV_WAIT -> returns to FILL, the next accepted block has buf_wr_addr=0 and acc_first=1, and all outputs are 0 during rst.
REQ-044 Random valid/ready/div_done latency over 1000 vectors -> scoreboard shows exactly IN_DEPTH writes and IN_DEPTH outputs per vector, and REQ-034 is never violated.

Source files
------------

// File: rtl/fixed_softmax_ctrl.sv
// Control FSM for a block-serial fixed-point softmax: buffers and accumulates
// one vector of exp blocks, then divides and emits each buffered block in turn.
module fixed_softmax_ctrl #(
  parameter int IN_DEPTH   = 10,
  parameter int ADDR_WIDTH = $clog2(IN_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in_0_valid,
  output logic                  data_in_0_ready,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic                  acc_en,
  output logic                  acc_first,
  input  logic                  sum_zero,
  output logic                  sum_load,
  output logic                  div_start,
  input  logic                  div_done,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  data_out_0_valid,
  input  logic                  data_out_0_ready,
  output logic                  out_last,
  output logic                  out_sat
);

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    SUM       = 3'd1,
    DIV_ISSUE = 3'd2,
    DIV_WAIT  = 3'd3,
    OUT       = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IN_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  sat_q;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = (state == FILL) && data_in_0_valid;
  assign out_fire = (state == OUT) && data_out_0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
      sat_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              state  <= SUM;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        SUM: begin
          // A zero sum skips the divider entirely; the datapath saturates instead.
          sat_q  <= sum_zero;
          rd_cnt <= '0;
          state  <= sum_zero ? OUT : DIV_ISSUE;
        end
        DIV_ISSUE: state <= DIV_WAIT;
        DIV_WAIT: begin
          if (div_done) state <= OUT;
        end
        OUT: begin
          if (out_fire) begin
            if (rd_cnt == LAST_IDX) begin
              rd_cnt <= '0;
              sat_q  <= 1'b0;
              state  <= FILL;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              state  <= sat_q ? OUT : DIV_ISSUE;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Outputs decode the registered state; everything is forced low while rst is high.
  always_comb begin
    data_in_0_ready  = 1'b0;
    buf_wr_en        = 1'b0;
    buf_wr_addr      = '0;
    acc_en           = 1'b0;
    acc_first        = 1'b0;
    sum_load         = 1'b0;
    div_start        = 1'b0;
    buf_rd_addr      = '0;
    data_out_0_valid = 1'b0;
    out_last         = 1'b0;
    out_sat          = 1'b0;
    if (!rst) begin
      buf_wr_addr = wr_cnt;
      buf_rd_addr = rd_cnt;
      case (state)
        FILL: begin
          data_in_0_ready = 1'b1;
          buf_wr_en       = in_fire;
          acc_en          = in_fire;
          acc_first       = in_fire && (wr_cnt == '0);
        end
        SUM:       sum_load  = 1'b1;
        DIV_ISSUE: div_start = 1'b1;
        OUT: begin
          data_out_0_valid = 1'b1;
          out_last         = (rd_cnt == LAST_IDX);
          out_sat          = sat_q;
        end
        default: ;
      endcase
    end
  end

endmodule
